seq_divider: RTL and testbench

//   Iterative unsigned divider built on the 4-bit add/subtract datapath. Computes quotient and remainder of

---
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one subtract-shift step per clock,
// start/done handshake, divide-by-zero flagged with saturated quotient.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DZ   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;

  logic [WIDTH:0]   r_shift_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] cnt_d;

  // One restoring step: shift next dividend bit into R, trial-subtract the divisor
  // as R + ~{0,divisor} + 1; the MSB of the difference is the borrow.
  always_comb begin
    r_shift_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff_d    = r_shift_d + ~{1'b0, dvsr_q} + {{WIDTH{1'b0}}, 1'b1};
    if (!diff_d[WIDTH]) begin
      r_d = diff_d;
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_d = r_shift_d;
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            q_q     <= dividend;
            r_q     <= '0;
            cnt_q   <= '0;
            dvsr_q  <= divisor;
            busy_q  <= 1'b1;
            state_q <= (divisor == '0) ? S_DZ : S_RUN;
          end
        end
        S_RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_d;
          if (cnt_d == LAST_CNT) begin
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_DZ: begin
          // q_q still holds the untouched captured dividend here.
          quot_q  <= '1;
          rem_q   <= q_q;
          dz_q    <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a shuffled sweep
// of every 4-bit operand pair against plain-arithmetic expectations.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a division and returns the number of edges after the start edge until
  // done is seen (-1 if it never comes). Operands are scrambled after capture.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, output int cycles);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    cycles   = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (done === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b q=%0d r=%0d dz=%b, required all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int cyc;
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after_start: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    cyc = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
    n_cmp++;
    if (cyc !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, required 4", cyc);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero, busy} !== {4'd4, 4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_13_3: q=%0d r=%0d dz=%b busy=%b, required q=4 r=1 dz=0 busy=0",
               quotient, remainder, div_by_zero, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b q=%0d r=%0d, required done=0 q=4 r=1",
               done, quotient, remainder);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] a_tab[3] = '{4'd15, 4'd3, 4'd0};
    logic [W-1:0] b_tab[3] = '{4'd1, 4'd9, 4'd5};
    logic [W-1:0] q_tab[3] = '{4'd15, 4'd0, 4'd0};
    logic [W-1:0] r_tab[3] = '{4'd0, 4'd3, 4'd0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      do_div(a_tab[i], b_tab[i], cyc);
      n_cmp++;
      if (cyc !== 4 || quotient !== q_tab[i] || remainder !== r_tab[i] || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL pattern_%0d_%0d: lat=%0d q=%0d r=%0d dz=%b, required lat=4 q=%0d r=%0d dz=0",
                 a_tab[i], b_tab[i], cyc, quotient, remainder, div_by_zero, q_tab[i], r_tab[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    do_div(4'd7, 4'd0, cyc);
    n_cmp++;
    if (cyc !== 1 || quotient !== 4'hF || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL divzero_7_0: lat=%0d q=%h r=%0d dz=%b, required lat=1 q=f r=7 dz=1",
               cyc, quotient, remainder, div_by_zero);
    end
    do_div(4'd6, 4'd2, cyc);
    n_cmp++;
    if (cyc !== 4 || quotient !== 4'd3 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_then_6_2: lat=%0d q=%0d r=%0d dz=%b, required lat=4 q=3 r=0 dz=0",
               cyc, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 4'd9;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_ignored_state: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    cyc = -1;
    for (int k = 3; k <= 16; k++) begin
      tick();
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
    n_cmp++;
    if (cyc !== 4 || quotient !== 4'd3 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_14_4: lat=%0d q=%0d r=%0d dz=%b, required lat=4 q=3 r=2 dz=0",
               cyc, quotient, remainder, div_by_zero);
    end
    do_div(4'd9, 4'd3, cyc);
    n_cmp++;
    if (cyc !== 4 || quotient !== 4'd3 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL back_to_back_9_3: lat=%0d q=%0d r=%0d, required lat=4 q=3 r=0",
               cyc, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int cyc;
    logic seen_done;
    dividend = 4'd11;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL midflight_reset_outputs: busy=%b done=%b q=%0d r=%0d dz=%b, required all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_no_done: activity=%b, required 0", seen_done);
    end
    do_div(4'd11, 4'd2, cyc);
    n_cmp++;
    if (cyc !== 4 || quotient !== 4'd5 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_11_2: lat=%0d q=%0d r=%0d dz=%b, required lat=4 q=5 r=1 dz=0",
               cyc, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_random_sweep();
    int order[256];
    int tmp, j, cyc, a, b, exp_lat;
    logic [W-1:0] exp_q, exp_r;
    logic         exp_dz;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      a = order[i] / 16;
      b = order[i] % 16;
      if (b == 0) begin
        exp_q = 4'hF;
        exp_r = W'(a);
        exp_dz = 1'b1;
        exp_lat = 1;
      end else begin
        exp_q = W'(a / b);
        exp_r = W'(a % b);
        exp_dz = 1'b0;
        exp_lat = 4;
      end
      do_div(W'(a), W'(b), cyc);
      n_cmp++;
      if (cyc !== exp_lat || quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_dz) begin
        n_fail++;
        $display("FAIL sweep_%0d_%0d: lat=%0d q=%0d r=%0d dz=%b, required lat=%0d q=%0d r=%0d dz=%b",
                 a, b, cyc, quotient, remainder, div_by_zero, exp_lat, exp_q, exp_r, exp_dz);
      end
      if (b != 0) begin
        n_cmp++;
        if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b) begin
          n_fail++;
          $display("FAIL sweep_invariant_%0d_%0d: q=%0d r=%0d, required q*d+r=%0d and r<%0d",
                   a, b, quotient, remainder, a, b);
        end
      end
      // Random idle gap; zero gap exercises back-to-back starts in the done cycle.
      for (int g = int'($urandom_range(2, 0)); g > 0; g--) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_back_to_back();
    test_reset_midflight();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
